// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl
//   Sequencing controller for the 5-stage core. It detects load-use hazards,
//   flushes on taken branches and holds EX while a multi-cycle MDU op runs.
//   It also produces registered one-hot forwarding selects for the EX
//   operand muxes: 001 = ID/EX operand, 010 = EX/MEM, 100 = MEM/WB.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   id_rs/id_rt, id_use_rs/rt   source registers of the ID instruction
//   id_mdu_op                   ID instruction is a multi-cycle MDU op
//   idex_dest/_reg_write/_mem_read   EX instruction destination info
//   exmem_dest/_reg_write       MEM instruction destination info
//   ex_branch_taken             branch resolved taken in EX
//   fwdA, fwdB                  registered operand selects for EX
//   pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
//   ex_mem_bubble               pipeline register controls
//   mdu_busy                    MDU op holding EX
//   stall_cycles                saturating count of stall cycles
module ex_hazard_ctrl #(
   parameter int MDU_LATENCY = 4,
   parameter int PERF_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_mdu_op,
   input  logic [4:0]        idex_dest,
   input  logic              idex_reg_write,
   input  logic              idex_mem_read,
   input  logic [4:0]        exmem_dest,
   input  logic              exmem_reg_write,
   input  logic              ex_branch_taken,
   output logic [2:0]        fwdA,
   output logic [2:0]        fwdB,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              if_id_flush,
   output logic              id_ex_write,
   output logic              id_ex_bubble,
   output logic              ex_mem_bubble,
   output logic              mdu_busy,
   output logic [PERF_W-1:0] stall_cycles
);

   typedef enum logic {RUN, BUSY} state_t;

   localparam logic [2:0] SEL_ID  = 3'b001;
   localparam logic [2:0] SEL_EX  = 3'b010;
   localparam logic [2:0] SEL_MEM = 3'b100;
   // BUSY covers the MDU cycles after the issue cycle.
   localparam logic [3:0] MDU_CNT = 4'(MDU_LATENCY - 1);

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic [2:0]        fwdA_nxt, fwdB_nxt;
   logic              stall_inc;
   logic              hitA_ex, hitB_ex, hitA_mem, hitB_mem, load_use;

   // Register 0 is hardwired, so it never produces a hazard.
   assign hitA_ex  = id_use_rs & idex_reg_write  & (idex_dest  == id_rs) & (id_rs != 5'd0);
   assign hitB_ex  = id_use_rt & idex_reg_write  & (idex_dest  == id_rt) & (id_rt != 5'd0);
   assign hitA_mem = id_use_rs & exmem_reg_write & (exmem_dest == id_rs) & (id_rs != 5'd0);
   assign hitB_mem = id_use_rt & exmem_reg_write & (exmem_dest == id_rt) & (id_rt != 5'd0);
   assign load_use = idex_mem_read & (hitA_ex | hitB_ex);

   assign mdu_busy = (state == BUSY);

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      fwdA_nxt      = fwdA;
      fwdB_nxt      = fwdB;
      stall_inc     = 1'b0;
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_write   = 1'b1;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
      case (state)
         RUN: begin
            if (ex_branch_taken) begin
               // Wrong-path ID instruction is squashed; its hazards are moot.
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               fwdA_nxt     = SEL_ID;
               fwdB_nxt     = SEL_ID;
            end else if (load_use) begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_bubble = 1'b1;
               fwdA_nxt     = SEL_ID;
               fwdB_nxt     = SEL_ID;
               stall_inc    = 1'b1;
            end else begin
               fwdA_nxt = hitA_ex ? SEL_EX : hitA_mem ? SEL_MEM : SEL_ID;
               fwdB_nxt = hitB_ex ? SEL_EX : hitB_mem ? SEL_MEM : SEL_ID;
               if (id_mdu_op && (MDU_LATENCY > 1)) begin
                  cnt_nxt   = MDU_CNT;
                  state_nxt = BUSY;
               end
            end
         end
         BUSY: begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            stall_inc     = 1'b1;
            cnt_nxt       = cnt - 4'd1;
            if (cnt == 4'd1) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
      // Hold the front end in a clean NOP state while in reset.
      if (rst) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_write   = 1'b1;
         id_ex_bubble  = 1'b1;
         ex_mem_bubble = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         cnt          <= 4'd0;
         fwdA         <= SEL_ID;
         fwdB         <= SEL_ID;
         stall_cycles <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         fwdA  <= fwdA_nxt;
         fwdB  <= fwdB_nxt;
         if (stall_inc && (stall_cycles != {PERF_W{1'b1}}))
            stall_cycles <= stall_cycles + {{(PERF_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl. Three instances share the stimulus:
// default parameters, MDU_LATENCY = 1, and PERF_W = 4 for saturation.
module tb_ex_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, idex_dest, exmem_dest;
   logic       id_use_rs, id_use_rt, id_mdu_op;
   logic       idex_reg_write, idex_mem_read, exmem_reg_write, ex_branch_taken;

   logic [2:0]  fwdA, fwdB, l_fwdA, l_fwdB, s_fwdA, s_fwdB;
   logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
   logic        ex_mem_bubble, mdu_busy;
   logic [15:0] stall_cycles, l_stall;
   logic        l_pc, l_ifw, l_iff, l_iew, l_ieb, l_emb, l_busy;
   logic        s_pc, s_ifw, s_iff, s_iew, s_ieb, s_emb, s_busy;
   logic [3:0]  s_stall;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   ex_hazard_ctrl u_dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_mdu_op(id_mdu_op),
      .idex_dest(idex_dest), .idex_reg_write(idex_reg_write),
      .idex_mem_read(idex_mem_read), .exmem_dest(exmem_dest),
      .exmem_reg_write(exmem_reg_write), .ex_branch_taken(ex_branch_taken),
      .fwdA(fwdA), .fwdB(fwdB), .pc_write(pc_write), .if_id_write(if_id_write),
      .if_id_flush(if_id_flush), .id_ex_write(id_ex_write),
      .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
      .mdu_busy(mdu_busy), .stall_cycles(stall_cycles));

   ex_hazard_ctrl #(.MDU_LATENCY(1)) u_lat1 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_mdu_op(id_mdu_op),
      .idex_dest(idex_dest), .idex_reg_write(idex_reg_write),
      .idex_mem_read(idex_mem_read), .exmem_dest(exmem_dest),
      .exmem_reg_write(exmem_reg_write), .ex_branch_taken(ex_branch_taken),
      .fwdA(l_fwdA), .fwdB(l_fwdB), .pc_write(l_pc), .if_id_write(l_ifw),
      .if_id_flush(l_iff), .id_ex_write(l_iew), .id_ex_bubble(l_ieb),
      .ex_mem_bubble(l_emb), .mdu_busy(l_busy), .stall_cycles(l_stall));

   ex_hazard_ctrl #(.PERF_W(4)) u_sat (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_mdu_op(id_mdu_op),
      .idex_dest(idex_dest), .idex_reg_write(idex_reg_write),
      .idex_mem_read(idex_mem_read), .exmem_dest(exmem_dest),
      .exmem_reg_write(exmem_reg_write), .ex_branch_taken(ex_branch_taken),
      .fwdA(s_fwdA), .fwdB(s_fwdB), .pc_write(s_pc), .if_id_write(s_ifw),
      .if_id_flush(s_iff), .id_ex_write(s_iew), .id_ex_bubble(s_ieb),
      .ex_mem_bubble(s_emb), .mdu_busy(s_busy), .stall_cycles(s_stall));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_mdu_op = 0;
      idex_dest = 0; idex_reg_write = 0; idex_mem_read = 0;
      exmem_dest = 0; exmem_reg_write = 0; ex_branch_taken = 0;
   endtask

   task automatic set_load_use();
      idle();
      idex_dest = 5'd8; idex_reg_write = 1; idex_mem_read = 1;
      id_rt = 5'd8; id_use_rt = 1;
   endtask

   initial begin
      int busy_n;
      idle();
      rst = 1;
      // Reset
      tick(); tick();
      chk("rst_fwdA", fwdA, 3'b001);
      chk("rst_fwdB", fwdB, 3'b001);
      chk("rst_stall", stall_cycles, 0);
      chk("rst_flush", if_id_flush, 1);
      chk("rst_pc_write", pc_write, 0);
      chk("rst_bubble", id_ex_bubble, 1);
      chk("rst_id_ex_write", id_ex_write, 1);
      rst = 0;
      #1;
      chk("run_pc_write", pc_write, 1);
      chk("run_flush", if_id_flush, 0);

      // EX-to-EX forward on rs
      idex_dest = 5'd5; idex_reg_write = 1; id_rs = 5'd5; id_use_rs = 1;
      #1 chk("fwd_ex_pc", pc_write, 1);
      tick();
      chk("fwd_ex_A", fwdA, 3'b010);
      chk("fwd_ex_B", fwdB, 3'b001);
      // Register 0 never forwards
      idex_dest = 5'd0; id_rs = 5'd0;
      tick();
      chk("fwd_r0_A", fwdA, 3'b001);
      // MEM-to-EX forward on rt
      idle();
      exmem_dest = 5'd7; exmem_reg_write = 1; id_rt = 5'd7; id_use_rt = 1;
      tick();
      chk("fwd_mem_B", fwdB, 3'b100);
      chk("fwd_mem_A", fwdA, 3'b001);

      // Load-use stall then MEM forward
      set_load_use();
      #1;
      chk("lu_pc_write", pc_write, 0);
      chk("lu_if_id_write", if_id_write, 0);
      chk("lu_bubble", id_ex_bubble, 1);
      tick();
      chk("lu_stall", stall_cycles, 1);
      chk("lu_fwdB", fwdB, 3'b001);
      idle();
      id_rt = 5'd8; id_use_rt = 1; exmem_dest = 5'd8; exmem_reg_write = 1;
      #1;
      chk("lu_adv_pc", pc_write, 1);
      chk("lu_adv_bubble", id_ex_bubble, 0);
      tick();
      chk("lu_adv_fwdB", fwdB, 3'b100);
      chk("lu_adv_stall", stall_cycles, 1);

      // MDU issue with an EX forward on rs; selects must hold through BUSY
      idle();
      idex_dest = 5'd5; idex_reg_write = 1; id_rs = 5'd5; id_use_rs = 1; id_mdu_op = 1;
      tick();
      chk("mdu_issue_fwdA", fwdA, 3'b010);
      chk("lat1_no_busy", l_busy, 0);
      idle();
      ex_branch_taken = 1;  // ignored while BUSY
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("mdu_busy", mdu_busy, 1);
         chk("mdu_emb", ex_mem_bubble, 1);
         chk("mdu_pc_write", pc_write, 0);
         chk("mdu_flush", if_id_flush, 0);
         tick();
         chk("mdu_fwdA_hold", fwdA, 3'b010);
      end
      ex_branch_taken = 0;
      #1;
      chk("mdu_done", mdu_busy, 0);
      chk("mdu_stall", stall_cycles, 4);

      // Branch beats load-use
      set_load_use();
      ex_branch_taken = 1;
      #1;
      chk("br_flush", if_id_flush, 1);
      chk("br_bubble", id_ex_bubble, 1);
      chk("br_pc_write", pc_write, 1);
      tick();
      chk("br_stall", stall_cycles, 4);
      chk("br_fwdA", fwdA, 3'b001);

      // 20-cycle stall stream; the 4-bit counter saturates
      set_load_use();
      repeat (20) tick();
      chk("sat_perf4", s_stall, 15);
      chk("sat_perf16", stall_cycles, 24);

      // Reset during the second BUSY cycle aborts the MDU op
      idle();
      id_mdu_op = 1;
      tick();
      idle();
      tick();
      rst = 1;
      tick();
      chk("rst_busy_state", mdu_busy, 0);
      chk("rst_busy_cnt", u_dut.cnt, 0);
      chk("rst_busy_stall", stall_cycles, 0);
      rst = 0;
      // Fresh MDU op still occupies exactly 3 BUSY cycles (bounded wait)
      id_mdu_op = 1;
      tick();
      idle();
      busy_n = 0;
      for (int i = 0; i < 10 && mdu_busy; i++) begin
         busy_n++;
         tick();
      end
      chk("mdu_rerun_len", busy_n, 3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
